// File: rtl/div_restoring_param_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The master side issues operations; the slave side (the divider) returns results.
interface div_restoring_param_if #(
  parameter int N = 8,
  parameter int M = 4
);
  localparam int CW = $clog2(N + 1);

  logic          start;
  logic          sgn;
  logic [N-1:0]  a;
  logic [M-1:0]  b;
  logic [N-1:0]  q;
  logic [M-1:0]  r;
  logic          dz;
  logic          busy;
  logic          ready;
  logic [CW-1:0] count;

  modport master (
    output start, sgn, a, b,
    input  q, r, dz, busy, ready, count
  );

  modport slave (
    input  start, sgn, a, b,
    output q, r, dz, busy, ready, count
  );
endinterface

// File: rtl/div_restoring_param.sv
// Sequential restoring divider, one quotient bit per clock, unsigned or
// truncating signed per operation, with divide-by-zero detection.
module div_restoring_param #(
  parameter int N = 8,
  parameter int M = 4
) (
  input logic                  clk,
  input logic                  clr,
  div_restoring_param_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ZERO
  } state_t;

  state_t state, state_next;

  // Operation context captured at accept.
  logic [N-1:0] dvd;      // dividend magnitude, shifted out MSB first
  logic [M-1:0] dvs;      // divisor magnitude
  logic [M:0]   rem;      // partial remainder
  logic [N-1:0] quo;      // quotient bits collected so far
  logic         neg_q;
  logic         neg_r;
  logic [M-1:0] a_lo;     // raw low dividend bits, reported as r on divide-by-zero

  logic [N-1:0] a_mag;
  logic [M-1:0] b_mag;
  logic         accept;
  logic         last;

  logic [M:0]   r_shift;
  logic [M+1:0] diff;
  logic         q_bit;
  logic [M:0]   rem_next;
  logic [N-1:0] quo_next;
  logic [M-1:0] rem_fin;

  assign accept = (state == S_IDLE) && bus.start;
  assign last   = (bus.count == CW'(N - 1));
  assign a_mag  = (bus.sgn && bus.a[N-1]) ? -bus.a : bus.a;
  assign b_mag  = (bus.sgn && bus.b[M-1]) ? -bus.b : bus.b;

  // One restoring step; the extra top bit of diff is the borrow, since the
  // shifted remainder can itself reach bit M while still being >= the divisor.
  assign r_shift  = {rem[M-1:0], dvd[N-1]};
  assign diff     = {1'b0, r_shift} - {2'b00, dvs};
  assign q_bit    = ~diff[M+1];
  assign rem_next = q_bit ? diff[M:0] : r_shift;
  assign quo_next = {quo[N-2:0], q_bit};
  assign rem_fin  = rem_next[M-1:0];

  assign bus.busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_next = (bus.b == '0) ? S_ZERO : S_RUN;
      end
      S_RUN: begin
        if (last) state_next = S_IDLE;
      end
      S_ZERO:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the datapath is small enough that every register is cleared by clr,
  // keeping the block fully deterministic after reset in simulation and silicon.
  always_ff @(posedge clk) begin
    if (clr) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      a_lo      <= '0;
      bus.q     <= '0;
      bus.r     <= '0;
      bus.dz    <= 1'b0;
      bus.ready <= 1'b0;
      bus.count <= '0;
    end else begin
      bus.ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            dvd       <= a_mag;
            dvs       <= b_mag;
            rem       <= '0;
            quo       <= '0;
            neg_q     <= bus.sgn & (bus.a[N-1] ^ bus.b[M-1]);
            neg_r     <= bus.sgn & bus.a[N-1];
            a_lo      <= bus.a[M-1:0];
            bus.dz    <= 1'b0;
            bus.count <= '0;
          end
        end
        S_RUN: begin
          dvd       <= {dvd[N-2:0], 1'b0};
          rem       <= rem_next;
          quo       <= quo_next;
          bus.count <= bus.count + CW'(1);
          if (last) begin
            bus.q     <= neg_q ? -quo_next : quo_next;
            bus.r     <= neg_r ? -rem_fin : rem_fin;
            bus.ready <= 1'b1;
          end
        end
        S_ZERO: begin
          bus.q     <= '1;
          bus.r     <= a_lo;
          bus.dz    <= 1'b1;
          bus.ready <= 1'b1;
          bus.count <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
